haar_cascade_sequencer: RTL and testbench

- Controller for the first-stage Haar cascade. It steps one shared classifier datapath through every classifier of every first-stage stage for one detection window.
- It accumulates per-stage haar values and compares each stage sum against its threshold. It exits early on the first failing stage.
- Sits between the window scanner (start/done) and the classifier block plus its parameter memory.

---
 rtl/haar_cascade_sequencer.sv | 162 ++++++++++++++++
 tb/tb_haar_cascade_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/haar_cascade_sequencer.sv
// Steps one shared classifier datapath through every classifier of every first-level stage of one window,
// exiting on the first failing stage; one request outstanding, ISSUE holds its address until i_clf_ready.
module haar_cascade_sequencer #(
  parameter int DATA_WIDTH                  = 8,
  parameter int ADDR_WIDTH                  = 12,
  parameter int ACC_WIDTH                   = 16,
  parameter int NUM_PARAM_PER_CLASSIFIER    = 18,
  parameter int NUM_CLASSIFIERS_PER_STAGE   = 50,
  parameter int NUM_FIRST_CLASSIFIER_STAGES = 3,
  localparam int STAGE_W = (NUM_FIRST_CLASSIFIER_STAGES > 1) ? $clog2(NUM_FIRST_CLASSIFIER_STAGES) : 1
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic [STAGE_W-1:0]    o_stage_idx,
  input  logic [DATA_WIDTH-1:0] i_stage_count,
  input  logic [DATA_WIDTH-1:0] i_stage_threshold,
  output logic                  o_clf_req,
  input  logic                  i_clf_ready,
  output logic [ADDR_WIDTH-1:0] o_param_base,
  input  logic                  i_haar_valid,
  input  logic [DATA_WIDTH-1:0] i_haar_value,
  output logic                  o_done,
  output logic                  o_iscandidate,
  output logic [STAGE_W-1:0]    o_reject_stage
);

  localparam int CNT_W = $clog2(NUM_CLASSIFIERS_PER_STAGE + 1);
  localparam int CMP_W = (ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] thr_q, thr_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  cand_q, cand_d;
  logic [STAGE_W-1:0]    rej_q, rej_d;

  logic [CNT_W-1:0]      cnt_ld;
  logic [ACC_WIDTH:0]    sum_w;
  logic [ACC_WIDTH-1:0]  acc_sat;
  logic                  idx_last;
  logic                  last_stage;
  logic                  stage_pass;
  logic                  aborting;

  always_comb begin
    cnt_ld     = (32'(i_stage_count) > 32'(NUM_CLASSIFIERS_PER_STAGE)) ?
                 CNT_W'(NUM_CLASSIFIERS_PER_STAGE) : CNT_W'(i_stage_count);
    sum_w      = {1'b0, acc_q} + (ACC_WIDTH+1)'(i_haar_value);
    acc_sat    = sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
    idx_last   = (idx_q == cnt_q - CNT_W'(1));
    last_stage = (stage_q == STAGE_W'(NUM_FIRST_CLASSIFIER_STAGES - 1));
    stage_pass = (CMP_W'(acc_q) > CMP_W'(thr_q));
    aborting   = i_abort && (state_q != S_IDLE);
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_LOAD;
      S_LOAD:  state_d = (cnt_ld == '0) ? S_CHECK : S_ISSUE;
      S_ISSUE: if (i_clf_ready) state_d = S_WAIT;
      S_WAIT:  if (i_haar_valid) state_d = idx_last ? S_CHECK : S_ISSUE;
      S_CHECK: state_d = (stage_pass && !last_stage) ? S_LOAD : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (aborting) state_d = S_IDLE;
  end

  always_comb begin
    stage_d = stage_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    cand_d  = cand_q;
    rej_d   = rej_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        stage_d = '0;
        cand_d  = 1'b0;
        rej_d   = '0;
      end
      S_LOAD: begin
        cnt_d = cnt_ld;
        thr_d = i_stage_threshold;
        acc_d = '0;
        idx_d = '0;
      end
      S_WAIT: if (i_haar_valid) begin
        acc_d = acc_sat;
        if (!idx_last) idx_d = idx_q + CNT_W'(1);
      end
      S_CHECK: begin
        if (!stage_pass) begin
          cand_d = 1'b0;
          rej_d  = stage_q;
        end else if (last_stage) begin
          cand_d = 1'b1;
          rej_d  = '0;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
        end
      end
      default: ;
    endcase
    // An abandoned window leaves no stale result and restarts cleanly from stage 0.
    if (aborting) begin
      stage_d = '0;
      idx_d   = '0;
      acc_d   = '0;
      cand_d  = 1'b0;
      rej_d   = '0;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      stage_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      thr_q   <= '0;
      acc_q   <= '0;
      cand_q  <= 1'b0;
      rej_q   <= '0;
    end else begin
      stage_q <= stage_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    o_busy         = (state_q != S_IDLE);
    o_clf_req      = (state_q == S_ISSUE);
    o_done         = (state_q == S_DONE);
    o_stage_idx    = stage_q;
    o_iscandidate  = cand_q;
    o_reject_stage = rej_q;
    o_param_base   = '0;
    if (state_q == S_ISSUE)
      o_param_base = ADDR_WIDTH'((32'(stage_q) * 32'(NUM_CLASSIFIERS_PER_STAGE) + 32'(idx_q))
                                 * 32'(NUM_PARAM_PER_CLASSIFIER));
  end

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Bench for haar_cascade_sequencer: window-level model (address list, result, latency) plus a
// negedge classifier responder that checks every request against that model.
`timescale 1ns/1ps
module tb_haar_cascade_sequencer;
  localparam int NS = 3;
  localparam int NC = 50;
  localparam int NP = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, ready, hvalid;
  logic [7:0] hvalue, scount, sthr;
  logic       busy0, req0, done0, cand0;
  logic [1:0] sidx0, rej0;
  logic [11:0] base0;
  logic       busy1, req1, done1, cand1;
  logic [1:0] sidx1, rej1;
  logic [11:0] base1;

  logic [7:0] cfg_cnt [NS];
  logic [7:0] cfg_thr [NS];
  int         hv [NS][NC];

  int pass_cnt = 0, chk_cnt = 0;
  int done_cnt = 0, acc_cnt = 0;
  int stall_n = 0, lat_n = 1;
  bit spurious = 0;

  int exp_q[$];
  int exp_lat, exp_cand16, exp_rej16, exp_cand8, exp_rej8;

  assign scount = (sidx0 < 2'd3) ? cfg_cnt[sidx0] : 8'd0;
  assign sthr   = (sidx0 < 2'd3) ? cfg_thr[sidx0] : 8'd0;

  haar_cascade_sequencer dut0 (
    .clk_fpga(clk), .reset_fpga(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy0), .o_stage_idx(sidx0), .i_stage_count(scount), .i_stage_threshold(sthr),
    .o_clf_req(req0), .i_clf_ready(ready), .o_param_base(base0),
    .i_haar_valid(hvalid), .i_haar_value(hvalue),
    .o_done(done0), .o_iscandidate(cand0), .o_reject_stage(rej0));

  // Narrow-accumulator instance rides on the same stimulus to exercise saturation.
  haar_cascade_sequencer #(.ACC_WIDTH(8)) dut1 (
    .clk_fpga(clk), .reset_fpga(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy1), .o_stage_idx(sidx1), .i_stage_count(scount), .i_stage_threshold(sthr),
    .o_clf_req(req1), .i_clf_ready(ready), .o_param_base(base1),
    .i_haar_valid(hvalid), .i_haar_value(hvalue),
    .o_done(done1), .o_iscandidate(cand1), .o_reject_stage(rej1));

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic fill_hv(input int v);
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < NC; i++) hv[s][i] = v;
  endtask

  task automatic set_cfg(input int c0, c1, c2, t0, t1, t2);
    cfg_cnt[0] = 8'(c0); cfg_cnt[1] = 8'(c1); cfg_cnt[2] = 8'(c2);
    cfg_thr[0] = 8'(t0); cfg_thr[1] = 8'(t1); cfg_thr[2] = 8'(t2);
  endtask

  // Window model: stage sums with saturation, strict compare, early exit.
  task automatic predict();
    int c, s8, s16;
    bit end8, end16;
    exp_q.delete();
    exp_lat = 1; exp_cand16 = 1; exp_rej16 = 0; exp_cand8 = 1; exp_rej8 = 0;
    end8 = 0; end16 = 0;
    for (int s = 0; s < NS; s++) begin
      c = (cfg_cnt[s] > NC) ? NC : int'(cfg_cnt[s]);
      s8 = 0; s16 = 0;
      for (int i = 0; i < c; i++) begin
        if (!end16) exp_q.push_back(((s * NC + i) * NP) % 4096);
        s16 = (s16 + hv[s][i] > 65535) ? 65535 : s16 + hv[s][i];
        s8  = (s8 + hv[s][i] > 255) ? 255 : s8 + hv[s][i];
      end
      if (!end16) begin
        exp_lat += 2 + 2 * c;
        if (!(s16 > int'(cfg_thr[s]))) begin exp_cand16 = 0; exp_rej16 = s; end16 = 1; end
      end
      if (!end8 && !(s8 > int'(cfg_thr[s]))) begin exp_cand8 = 0; exp_rej8 = s; end8 = 1; end
    end
  endtask

  // Classifier responder and per-cycle request checker.
  initial begin : responder
    int pend, pval, stall, idx;
    bit stalled_prev;
    logic [11:0] prev_base;
    pend = 0; pval = 0; stall = 0; stalled_prev = 0; prev_base = '0;
    ready = 1'b1; hvalid = 1'b0; hvalue = 8'd0;
    forever begin
      @(negedge clk);
      hvalid = 1'b0; hvalue = 8'd0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin hvalid = 1'b1; hvalue = 8'(pval); end
      end
      if (done0) done_cnt++;
      if (req0) begin
        check("busy_while_req", int'(busy0), 1);
        if (stalled_prev) check("base_stable_stall", int'(base0), int'(prev_base));
        if (stall < stall_n) begin
          ready = 1'b0;
          stall++;
          if (spurious) begin hvalid = 1'b1; hvalue = 8'd99; end
        end else begin
          ready = 1'b1;
          stall = 0;
          acc_cnt++;
          if (exp_q.size() == 0) check("unexpected_req_addr", int'(base0), -1);
          else check("req_addr", int'(base0), exp_q.pop_front());
          idx = (int'(base0) / NP) % NC;
          pval = (sidx0 < 2'd3) ? hv[sidx0][idx] : 0;
          pend = lat_n;
        end
        stalled_prev = !ready;
        prev_base = base0;
      end else begin
        ready = 1'b1;
        stalled_prev = 0;
      end
    end
  end

  task automatic run_window(input string tag, input bit chk_lat);
    int n, d0;
    predict();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_cand_cleared"}, int'(cand0), 0);
    check({tag, "_rej_cleared"}, int'(rej0), 0);
    n = 0;
    while (!done0 && n < 5000) begin @(posedge clk); #1; n++; end
    check({tag, "_done_seen"}, int'(done0), 1);
    // o_done is sampled by the scanner on the edge after it rises.
    if (chk_lat) check({tag, "_latency"}, n + 1, exp_lat);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, int'(done0), 0);
    check({tag, "_idle_busy"}, int'(busy0), 0);
    check({tag, "_cand"}, int'(cand0), exp_cand16);
    check({tag, "_rej"}, int'(rej0), exp_rej16);
    check({tag, "_cand_acc8"}, int'(cand1), exp_cand8);
    check({tag, "_rej_acc8"}, int'(rej1), exp_rej8);
    check({tag, "_reqs_left"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic check_idle_cleared(input string tag);
    check({tag, "_busy"}, int'(busy0), 0);
    check({tag, "_req"}, int'(req0), 0);
    check({tag, "_done"}, int'(done0), 0);
    check({tag, "_cand"}, int'(cand0), 0);
    check({tag, "_rej"}, int'(rej0), 0);
    check({tag, "_stage"}, int'(sidx0), 0);
    check({tag, "_base"}, int'(base0), 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

  initial begin : main
    int a0, d0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(2, 2, 2, 10, 10, 10);
    fill_hv(6);
    repeat (3) @(posedge clk);
    #1;
    check_idle_cleared("reset");
    rst = 1'b0;

    // Pass all stages; pin the model with hand-computed values first.
    predict();
    check("model_pass_lat", exp_lat, 19);
    check("model_pass_nreq", exp_q.size(), 6);
    check("model_addr2", exp_q[2], 900);
    check("model_addr5", exp_q[5], 1818);
    run_window("pass_all", 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_cand", int'(cand0), 1);

    // Early reject at stage 1 (5+5 is not greater than 10).
    hv[1][0] = 5; hv[1][1] = 5;
    predict();
    check("model_early_nreq", exp_q.size(), 4);
    check("model_early_rej", exp_rej16, 1);
    run_window("early_rej", 1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_rej", int'(rej0), 1);

    // Zero-count stage with zero threshold fails.
    fill_hv(6);
    set_cfg(2, 2, 0, 10, 10, 0);
    predict();
    check("model_zero_lat", exp_lat, 15);
    run_window("zero_cnt", 1);

    // Oversized count clamps to 50 classifiers.
    fill_hv(1);
    set_cfg(200, 1, 1, 40, 0, 0);
    predict();
    check("model_clamp_nreq", exp_q.size(), 52);
    check("model_clamp_lat", exp_lat, 111);
    run_window("clamp", 1);

    // Backpressure, slow results and spurious valids in ISSUE.
    fill_hv(1);
    hv[0][0] = 7; hv[0][1] = 8; hv[0][2] = 9; hv[1][0] = 5;
    set_cfg(3, 1, 1, 23, 5, 0);
    stall_n = 3; lat_n = 5; spurious = 1;
    run_window("backpressure", 0);
    check("bp_model_rej", exp_rej16, 1);
    stall_n = 0; lat_n = 1; spurious = 0;

    // Saturation: 200+100 clamps to 255 in the narrow accumulator.
    fill_hv(1);
    hv[0][0] = 200; hv[0][1] = 100;
    set_cfg(2, 1, 1, 254, 0, 0);
    run_window("sat_pass", 1);
    set_cfg(2, 1, 1, 255, 0, 0);
    predict();
    check("model_sat8_cand", exp_cand8, 0);
    check("model_sat16_cand", exp_cand16, 1);
    run_window("sat_edge", 1);

    // Abort during WAIT of stage 1.
    fill_hv(6);
    set_cfg(2, 2, 2, 10, 10, 10);
    predict();
    a0 = acc_cnt; d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (acc_cnt < a0 + 3 && n < 200) begin @(posedge clk); #1; n++; end
    check("abort_reached_wait", acc_cnt - a0, 3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_idle_cleared("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    exp_q.delete();
    run_window("after_abort", 1);

    // Reset during ISSUE of stage 1.
    predict();
    a0 = acc_cnt; d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(req0 && sidx0 == 2'd1) && n < 200) begin @(posedge clk); #1; n++; end
    check("reset_reached_issue", int'(req0 && sidx0 == 2'd1), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle_cleared("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    check("reset_no_done", done_cnt - d0, 0);
    exp_q.delete();
    run_window("after_reset", 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
